// File: rtl/axi_ram_pkg.sv
// Shared types and default widths for the AXI4 RAM arbiter slice.
package axi_ram_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 64;

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        WR_REQ,
        WR_RESP
    } state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } owner_e;

endpackage

// File: rtl/axi4_ram_arbiter_if.sv
// Requester ports of both masters plus the simplified AXI RAM port, bundled as one bus.
interface axi4_ram_arbiter_if
    import axi_ram_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);

    localparam int STRB_W = DATA_W / 8;

    logic              m0_req;
    logic [ADDR_W-1:0] m0_addr;
    logic              m0_gnt;
    logic              m0_rvalid;

    logic              m1_req;
    logic              m1_we;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_wdata;
    logic [STRB_W-1:0] m1_wstrb;
    logic              m1_gnt;
    logic              m1_rvalid;
    logic              m1_bvalid;

    logic [DATA_W-1:0] rsp_rdata;

    logic [ADDR_W-1:0] s_awaddr;
    logic              s_awvalid;
    logic              s_awready;
    logic [ADDR_W-1:0] s_araddr;
    logic              s_arvalid;
    logic              s_arready;
    logic [DATA_W-1:0] s_rdata;
    logic [DATA_W-1:0] s_wdata;
    logic [STRB_W-1:0] s_wstrb;
    logic              s_wvalid;
    logic              s_wready;
    logic              s_bvalid;

    // The arbiter is the master of the RAM port; the environment (cores + RAM) is the slave side.
    modport master (
        input  m0_req, m0_addr,
        input  m1_req, m1_we, m1_addr, m1_wdata, m1_wstrb,
        input  s_awready, s_arready, s_rdata, s_wready, s_bvalid,
        output m0_gnt, m0_rvalid,
        output m1_gnt, m1_rvalid, m1_bvalid,
        output rsp_rdata,
        output s_awaddr, s_awvalid, s_araddr, s_arvalid,
        output s_wdata, s_wstrb, s_wvalid
    );

    modport slave (
        output m0_req, m0_addr,
        output m1_req, m1_we, m1_addr, m1_wdata, m1_wstrb,
        output s_awready, s_arready, s_rdata, s_wready, s_bvalid,
        input  m0_gnt, m0_rvalid,
        input  m1_gnt, m1_rvalid, m1_bvalid,
        input  rsp_rdata,
        input  s_awaddr, s_awvalid, s_araddr, s_arvalid,
        input  s_wdata, s_wstrb, s_wvalid
    );

endinterface

// File: rtl/axi4_ram_arbiter.sv
// Round-robin arbiter sharing one AXI RAM port between ifetch (m0, read-only) and dmem (m1),
// with a single transaction outstanding at a time.
module axi4_ram_arbiter
    import axi_ram_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                clock,
    input  logic                reset,
    axi4_ram_arbiter_if.master  bus
);

    localparam int STRB_W = DATA_W / 8;

    state_e            state_q, state_d;
    owner_e            owner_q, owner_d;
    logic              rr_ptr_q, rr_ptr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [STRB_W-1:0] wstrb_q, wstrb_d;
    logic              aw_done_q, aw_done_d;
    logic              w_done_q, w_done_d;

    logic pick_m0;
    logic pick_m1;
    logic aw_valid;
    logic w_valid;

    // rr_ptr == 0 favours m1 when both request; gated by reset so no grant leaks out of reset.
    always_comb begin
        pick_m0 = 1'b0;
        pick_m1 = 1'b0;
        if (state_q == IDLE && !reset) begin
            if (bus.m1_req && (!bus.m0_req || !rr_ptr_q)) begin
                pick_m1 = 1'b1;
            end else if (bus.m0_req) begin
                pick_m0 = 1'b1;
            end
        end
    end

    assign aw_valid = (state_q == WR_REQ) && !aw_done_q;
    assign w_valid  = (state_q == WR_REQ) && !w_done_q;

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        rr_ptr_d  = rr_ptr_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        case (state_q)
            IDLE: begin
                if (pick_m1) begin
                    owner_d   = OWN_DM;
                    addr_d    = bus.m1_addr;
                    wdata_d   = bus.m1_wdata;
                    wstrb_d   = bus.m1_wstrb;
                    rr_ptr_d  = 1'b1;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = bus.m1_we ? WR_REQ : RD_ADDR;
                end else if (pick_m0) begin
                    owner_d  = OWN_IF;
                    addr_d   = bus.m0_addr;
                    rr_ptr_d = 1'b0;
                    state_d  = RD_ADDR;
                end
            end
            RD_ADDR: begin
                if (bus.s_arready) begin
                    state_d = RD_DATA;
                end
            end
            RD_DATA: begin
                state_d = IDLE;
            end
            // Address and data channels complete independently, possibly in the same cycle.
            WR_REQ: begin
                aw_done_d = aw_done_q | (aw_valid & bus.s_awready);
                w_done_d  = w_done_q | (w_valid & bus.s_wready);
                if (aw_done_d && w_done_d) begin
                    state_d = WR_RESP;
                end
            end
            WR_RESP: begin
                if (bus.s_bvalid) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            owner_q   <= OWN_IF;
            rr_ptr_q  <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            rr_ptr_q  <= rr_ptr_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

    assign bus.m0_gnt    = pick_m0;
    assign bus.m1_gnt    = pick_m1;
    assign bus.m0_rvalid = (state_q == RD_DATA) && (owner_q == OWN_IF);
    assign bus.m1_rvalid = (state_q == RD_DATA) && (owner_q == OWN_DM);
    assign bus.m1_bvalid = (state_q == WR_RESP) && bus.s_bvalid;
    assign bus.rsp_rdata = bus.s_rdata;

    assign bus.s_araddr  = addr_q;
    assign bus.s_arvalid = (state_q == RD_ADDR);
    assign bus.s_awaddr  = addr_q;
    assign bus.s_awvalid = aw_valid;
    assign bus.s_wdata   = wdata_q;
    assign bus.s_wstrb   = wstrb_q;
    assign bus.s_wvalid  = w_valid;

endmodule

// File: tb/tb_axi4_ram_arbiter.sv
// Directed bench: both masters plus a RAM model with programmable ready delays; responses are
// checked against a scoreboard filled when each request is granted.
module tb_axi4_ram_arbiter;
    import axi_ram_pkg::*;

    localparam int AW = 32;
    localparam int DW = 64;
    localparam int SW = DW / 8;

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    axi4_ram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus_if ();

    axi4_ram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus_if)
    );

    typedef struct {
        bit          is_wr;
        bit          owner;
        logic [31:0] addr;
        logic [63:0] data;
    } exp_t;

    exp_t sb[$];
    int   gnt_log[$];

    logic [63:0] ref_mem [logic [31:0]];
    logic [63:0] ram_mem [logic [31:0]];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    int ar_delay, aw_delay, w_delay;
    int ar_cnt, aw_cnt, w_cnt;
    bit rd_pending, aw_seen, w_seen, b_pending, force_b;
    logic [31:0] rd_addr, aw_addr_l;
    logic [63:0] wd_l;
    logic [7:0]  ws_l;

    bit m0_hold, m1_hold, m0_drop, m1_drop;
    int gnt_cyc, first_arv_cyc, rsp_cyc;
    int rv_count, bv_count, aw_hi, w_hi;
    logic [63:0] last_rdata;

    function automatic logic [63:0] init_word(logic [31:0] a);
        logic [31:0] k;
        k = a >> 3;
        return {k, ~k};
    endfunction

    function automatic logic [63:0] merge(logic [63:0] old, logic [63:0] d, logic [7:0] s);
        for (int b = 0; b < 8; b++) begin
            if (s[b]) old[8*b +: 8] = d[8*b +: 8];
        end
        return old;
    endfunction

    function automatic logic [63:0] ref_rd(logic [31:0] a);
        if (ref_mem.exists(a >> 3)) return ref_mem[a >> 3];
        return init_word(a);
    endfunction

    function automatic logic [63:0] ram_rd(logic [31:0] a);
        if (ram_mem.exists(a >> 3)) return ram_mem[a >> 3];
        return init_word(a);
    endfunction

    task automatic check_output(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // RAM model drives its ready/data/bresp inputs for the current cycle.
    task automatic ram_drive();
        bus_if.s_arready = bus_if.s_arvalid && (ar_cnt >= ar_delay);
        bus_if.s_awready = bus_if.s_awvalid && (aw_cnt >= aw_delay);
        bus_if.s_wready  = bus_if.s_wvalid && (w_cnt >= w_delay);
        bus_if.s_rdata   = rd_pending ? ram_rd(rd_addr) : 64'hBAD0_BAD0_BAD0_BAD0;
        rd_pending       = 1'b0;
        bus_if.s_bvalid  = b_pending || force_b;
        b_pending        = 1'b0;
        force_b          = 1'b0;
    endtask

    task automatic monitor();
        exp_t e;
        if (bus_if.s_arvalid) begin
            if (first_arv_cyc < 0) first_arv_cyc = cyc;
            if (bus_if.s_arready) begin
                check_output("ar_outstanding", 64'(sb.size()), 64'd1);
                if (sb.size() == 1) check_output("araddr", 64'(bus_if.s_araddr), 64'(sb[0].addr));
                rd_pending = 1'b1;
                rd_addr    = bus_if.s_araddr;
                ar_cnt     = 0;
            end else ar_cnt++;
        end
        if (bus_if.s_awvalid) begin
            aw_hi++;
            if (bus_if.s_awready) begin
                if (sb.size() == 1) check_output("awaddr", 64'(bus_if.s_awaddr), 64'(sb[0].addr));
                aw_seen   = 1'b1;
                aw_addr_l = bus_if.s_awaddr;
                aw_cnt    = 0;
            end else aw_cnt++;
        end
        if (bus_if.s_wvalid) begin
            w_hi++;
            if (bus_if.s_wready) begin
                w_seen = 1'b1;
                wd_l   = bus_if.s_wdata;
                ws_l   = bus_if.s_wstrb;
                w_cnt  = 0;
            end else w_cnt++;
        end
        if (aw_seen && w_seen) begin
            ram_mem[aw_addr_l >> 3] = merge(ram_rd(aw_addr_l), wd_l, ws_l);
            aw_seen   = 1'b0;
            w_seen    = 1'b0;
            b_pending = 1'b1;
        end
        if (bus_if.m0_gnt || bus_if.m1_gnt) begin
            check_output("one_outstanding", 64'(sb.size()), 64'd0);
            check_output("dual_gnt", 64'(bus_if.m0_gnt & bus_if.m1_gnt), 64'd0);
            gnt_cyc       = cyc;
            first_arv_cyc = -1;
            aw_hi         = 0;
            w_hi          = 0;
        end
        if (bus_if.m0_gnt) begin
            gnt_log.push_back(0);
            sb.push_back('{is_wr: 1'b0, owner: 1'b0, addr: bus_if.m0_addr, data: ref_rd(bus_if.m0_addr)});
            if (!m0_hold) m0_drop = 1'b1;
        end else if (bus_if.m1_gnt) begin
            gnt_log.push_back(1);
            if (bus_if.m1_we) begin
                ref_mem[bus_if.m1_addr >> 3] = merge(ref_rd(bus_if.m1_addr), bus_if.m1_wdata, bus_if.m1_wstrb);
                sb.push_back('{is_wr: 1'b1, owner: 1'b1, addr: bus_if.m1_addr, data: 64'd0});
            end else begin
                sb.push_back('{is_wr: 1'b0, owner: 1'b1, addr: bus_if.m1_addr, data: ref_rd(bus_if.m1_addr)});
            end
            if (!m1_hold) m1_drop = 1'b1;
        end
        if (bus_if.m0_rvalid || bus_if.m1_rvalid || bus_if.m1_bvalid) begin
            rsp_cyc = cyc;
            if (bus_if.m1_bvalid) bv_count++; else rv_count++;
            if (sb.size() == 0) begin
                check_output("spurious_rsp", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                check_output("rsp_owner", 64'(bus_if.m1_rvalid | bus_if.m1_bvalid), 64'(e.owner));
                check_output("rsp_kind", 64'(bus_if.m1_bvalid), 64'(e.is_wr));
                if (!e.is_wr) begin
                    check_output("rdata", bus_if.rsp_rdata, e.data);
                    last_rdata = bus_if.rsp_rdata;
                end
            end
        end
    endtask

    task automatic step_cycle();
        ram_drive();
        #1;
        monitor();
        @(posedge clock);
        #1;
        cyc++;
        if (m0_drop) begin bus_if.m0_req = 1'b0; m0_drop = 1'b0; end
        if (m1_drop) begin bus_if.m1_req = 1'b0; m1_drop = 1'b0; end
    endtask

    task automatic run_until_idle(string tag, int max);
        int n;
        n = 0;
        while ((sb.size() != 0 || bus_if.m0_req || bus_if.m1_req) && n < max) begin
            step_cycle();
            n++;
        end
        check_output(tag, 64'(n < max), 64'd1);
    endtask

    task automatic clear_ram_model();
        ar_cnt = 0; aw_cnt = 0; w_cnt = 0;
        rd_pending = 1'b0; aw_seen = 1'b0; w_seen = 1'b0; b_pending = 1'b0; force_b = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n, start, bv_before, rv_before;
        reset = 1'b1;
        bus_if.m0_req = 1'b0; bus_if.m0_addr = '0;
        bus_if.m1_req = 1'b0; bus_if.m1_we = 1'b0; bus_if.m1_addr = '0;
        bus_if.m1_wdata = '0; bus_if.m1_wstrb = '0;
        bus_if.s_arready = 1'b0; bus_if.s_awready = 1'b0; bus_if.s_wready = 1'b0;
        bus_if.s_rdata = '0; bus_if.s_bvalid = 1'b0;
        ar_delay = 0; aw_delay = 0; w_delay = 0;
        clear_ram_model();
        m0_hold = 1'b0; m1_hold = 1'b0; m0_drop = 1'b0; m1_drop = 1'b0;
        rv_count = 0; bv_count = 0; gnt_cyc = -1; first_arv_cyc = -1; rsp_cyc = -1;
        aw_hi = 0; w_hi = 0; last_rdata = '0;

        // Reset state, with both masters already requesting.
        bus_if.m0_req = 1'b1; bus_if.m0_addr = 32'h8000_0100;
        bus_if.m1_req = 1'b1; bus_if.m1_addr = 32'h8000_0200;
        @(posedge clock); @(posedge clock); #1;
        ram_drive(); #1;
        check_output("rst_m0_gnt", 64'(bus_if.m0_gnt), 64'd0);
        check_output("rst_m1_gnt", 64'(bus_if.m1_gnt), 64'd0);
        check_output("rst_arvalid", 64'(bus_if.s_arvalid), 64'd0);
        check_output("rst_awvalid", 64'(bus_if.s_awvalid), 64'd0);
        check_output("rst_wvalid", 64'(bus_if.s_wvalid), 64'd0);
        check_output("rst_rvalid", 64'({bus_if.m0_rvalid, bus_if.m1_rvalid, bus_if.m1_bvalid}), 64'd0);
        check_output("rst_araddr", 64'(bus_if.s_araddr), 64'd0);
        check_output("rst_wdata", bus_if.s_wdata, 64'd0);
        check_output("rst_wstrb", 64'(bus_if.s_wstrb), 64'd0);
        reset = 1'b0;

        // Both masters held: grants must alternate starting with m1.
        m0_hold = 1'b1; m1_hold = 1'b1;
        n = 0;
        while (gnt_log.size() < 4 && n < 60) begin step_cycle(); n++; end
        check_output("rr_grants_seen", 64'(gnt_log.size() >= 4), 64'd1);
        m0_hold = 1'b0; m1_hold = 1'b0;
        bus_if.m0_req = 1'b0; bus_if.m1_req = 1'b0;
        run_until_idle("rr_drain", 20);
        if (gnt_log.size() >= 4) begin
            check_output("rr_gnt0", 64'(gnt_log[0]), 64'd1);
            check_output("rr_gnt1", 64'(gnt_log[1]), 64'd0);
            check_output("rr_gnt2", 64'(gnt_log[2]), 64'd1);
            check_output("rr_gnt3", 64'(gnt_log[3]), 64'd0);
        end

        // Single m0 read: gnt N, arvalid N+1, rvalid N+2.
        bus_if.m0_addr = 32'h8000_0000; bus_if.m0_req = 1'b1;
        run_until_idle("m0_read_done", 20);
        check_output("m0_arvalid_lat", 64'(first_arv_cyc - gnt_cyc), 64'd1);
        check_output("m0_rvalid_lat", 64'(rsp_cyc - gnt_cyc), 64'd2);
        check_output("m0_rdata_word", last_rdata, 64'h1000_0000_EFFF_FFFF);

        // m1 partial write, awready two cycles late; then read it back.
        aw_delay = 2; w_delay = 0; bv_before = bv_count;
        bus_if.m1_addr = 32'h8000_0010; bus_if.m1_we = 1'b1;
        bus_if.m1_wdata = 64'h1122_3344_5566_7788; bus_if.m1_wstrb = 8'h0F;
        bus_if.m1_req = 1'b1;
        run_until_idle("wr_late_done", 30);
        check_output("wr_late_wvalid_cycles", 64'(w_hi), 64'd1);
        check_output("wr_late_awvalid_cycles", 64'(aw_hi), 64'd3);
        check_output("wr_late_bvalid_pulses", 64'(bv_count - bv_before), 64'd1);
        aw_delay = 0;
        bus_if.m1_we = 1'b0; bus_if.m1_req = 1'b1;
        run_until_idle("wr_late_readback", 20);
        check_output("wr_late_merge", last_rdata, 64'h1000_0002_5566_7788);

        // aw and w accepted together: exactly one WR_REQ cycle.
        bus_if.m1_addr = 32'h8000_0020; bus_if.m1_we = 1'b1;
        bus_if.m1_wdata = 64'hA5A5_5A5A_0F0F_F0F0; bus_if.m1_wstrb = 8'hFF;
        bus_if.m1_req = 1'b1;
        run_until_idle("wr_fast_done", 20);
        check_output("wr_fast_awvalid_cycles", 64'(aw_hi), 64'd1);
        check_output("wr_fast_wvalid_cycles", 64'(w_hi), 64'd1);
        check_output("wr_fast_bvalid_lat", 64'(rsp_cyc - gnt_cyc), 64'd2);
        bus_if.m0_addr = 32'h8000_0020; bus_if.m0_req = 1'b1;
        run_until_idle("wr_fast_readback", 20);
        check_output("wr_fast_data", last_rdata, 64'hA5A5_5A5A_0F0F_F0F0);

        // Reset while stuck in RD_ADDR abandons the read.
        ar_delay = 1000;
        bus_if.m0_addr = 32'h8000_0040; bus_if.m0_req = 1'b1;
        repeat (3) step_cycle();
        check_output("stuck_arvalid", 64'(bus_if.s_arvalid), 64'd1);
        reset = 1'b1;
        step_cycle();
        sb.delete();
        clear_ram_model();
        ar_delay = 0;
        ram_drive(); #1;
        check_output("rst_mid_arvalid", 64'(bus_if.s_arvalid), 64'd0);
        check_output("rst_mid_araddr", 64'(bus_if.s_araddr), 64'd0);
        reset = 1'b0;
        rv_before = rv_count;
        repeat (6) step_cycle();
        check_output("rst_mid_no_rvalid", 64'(rv_count - rv_before), 64'd0);
        start = cyc;
        bus_if.m0_req = 1'b1;
        run_until_idle("rst_mid_recover", 20);
        check_output("rst_mid_idle_gnt", 64'(gnt_cyc), 64'(start));

        // Stray s_bvalid in IDLE and in RD_DATA is ignored.
        bv_before = bv_count;
        force_b = 1'b1;
        step_cycle();
        step_cycle();
        bus_if.m1_addr = 32'h8000_0010; bus_if.m1_we = 1'b0; bus_if.m1_req = 1'b1;
        step_cycle();
        step_cycle();
        force_b = 1'b1;
        run_until_idle("stray_b_read", 20);
        check_output("stray_b_none", 64'(bv_count - bv_before), 64'd0);
        check_output("stray_b_rdata", last_rdata, 64'h1000_0002_5566_7788);
        bus_if.m0_addr = 32'h8000_0008; bus_if.m0_req = 1'b1;
        run_until_idle("stray_b_after", 20);
        check_output("stray_b_after_lat", 64'(rsp_cyc - gnt_cyc), 64'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
